// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing helpers and port-operation encoding for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int unsigned DEFAULT_BUS_WIDTH     = 8;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 8;

  // Operation the single RAM port carries in the current cycle.
  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_POP  = 2'd1,
    PORT_PUSH = 2'd2
  } port_op_e;

  function automatic int unsigned fifo_depth(input int unsigned address_width);
    return 32'd1 << address_width;
  endfunction

  function automatic int unsigned fifo_count_width(input int unsigned address_width);
    return address_width + 32'd1;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_ptr_counter.sv
// Wrapping up-counter used for the FIFO read and write pointers.
module ptr_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  // Natural modulo-2^WIDTH wrap from all-ones back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller driving a single-port RAM with combinational read.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = DEFAULT_BUS_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [BUS_WIDTH-1:0]       din,
  output logic                       push_ack,
  input  logic                       pop,
  output logic                       pop_ack,
  output logic [BUS_WIDTH-1:0]       dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic [ADDRESS_WIDTH:0]     count,
  output logic [ADDRESS_WIDTH-1:0]   ram_ad,
  output logic                       ram_st,
  output logic [BUS_WIDTH-1:0]       ram_x,
  input  logic [BUS_WIDTH-1:0]       ram_o
);

  localparam int unsigned DEPTH       = fifo_depth(ADDRESS_WIDTH);
  localparam int unsigned COUNT_WIDTH = fifo_count_width(ADDRESS_WIDTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [COUNT_WIDTH-1:0]   count_next;
  port_op_e                 op_c;

  // Pop wins the single port; push only proceeds when the port is otherwise free.
  assign pop_ack  = pop & ~empty;
  assign push_ack = push & ~full & ~pop_ack;
  assign ram_x    = din;

  always_comb begin
    op_c = PORT_IDLE;
    if (pop_ack) begin
      op_c = PORT_POP;
    end else if (push_ack) begin
      op_c = PORT_PUSH;
    end
  end

  // Address mux and occupancy update; idle cycles park the address on rd_ptr.
  always_comb begin
    ram_ad     = rd_ptr;
    ram_st     = 1'b0;
    count_next = count;
    unique case (op_c)
      PORT_POP: begin
        count_next = count - COUNT_WIDTH'(1);
      end
      PORT_PUSH: begin
        ram_ad     = wr_ptr;
        ram_st     = 1'b1;
        count_next = count + COUNT_WIDTH'(1);
      end
      default: begin
      end
    endcase
  end

  ptr_counter #(.WIDTH(ADDRESS_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push_ack),
    .ptr   (wr_ptr)
  );

  ptr_counter #(.WIDTH(ADDRESS_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop_ack),
    .ptr   (rd_ptr)
  );

  // Flags derive from the next count so they track count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == COUNT_WIDTH'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= pop_ack;
      if (pop_ack) begin
        dout <= ram_o;
      end
    end
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Controller that sits directly upstream of the single-port `ram` block and turns it into a synchronous FIFO.
- Drives the RAM's address, store-strobe and write-data inputs, and consumes its combinational read data.
- Serialises push and pop onto the one address bus and maintains the pointers, occupancy and full/empty flags.
- Used wherever the design needs buffering between producer and consumer stages.

Parameters:
- BUS_WIDTH, 8, data word width; must match the attached `ram`.
- ADDRESS_WIDTH, 8, RAM address width; FIFO depth is 1<<ADDRESS_WIDTH; must match the attached `ram`.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- push  in  1  producer requests write of din this cycle.
- din  in  BUS_WIDTH  write data.
- push_ack  out  1  combinational; push is accepted at this clock edge.
- pop  in  1  consumer requests a read this cycle.
- pop_ack  out  1  combinational; pop is accepted at this clock edge.
- dout  out  BUS_WIDTH  registered read data.
- dout_valid  out  1  registered; dout holds a newly popped word for one cycle.
- full  out  1  registered; count == depth.
- empty  out  1  registered; count == 0.
- count  out  ADDRESS_WIDTH+1  registered occupancy, 0..depth.
- ram_ad  out  ADDRESS_WIDTH  to ram `ad`.
- ram_st  out  1  to ram `st`.
- ram_x  out  BUS_WIDTH  to ram `X`.
- ram_o  in  BUS_WIDTH  from ram `O`; combinational read of ram_ad.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count, dout and dout_valid are set to 0; empty=1, full=0.
  - RAM contents are not cleared; they are irrelevant because the FIFO is empty.
  - A reset asserted mid-operation discards any in-flight push or pop.
- Arbitration: the single port serves one access per cycle.
  - pop_ack = pop & !empty.
  - push_ack = push & !full & !pop_ack.
  - Pop has priority over push; a stalled producer holds push and din until push_ack is seen.
- Port muxing (combinational):
  - pop_ack=1: ram_ad=rd_ptr, ram_st=0.
  - push_ack=1: ram_ad=wr_ptr, ram_st=1.
  - Otherwise: ram_ad=rd_ptr, ram_st=0.
  - ram_x = din at all times.
- On a push_ack edge: the RAM stores din at wr_ptr; wr_ptr += 1 modulo depth; count += 1.
- On a pop_ack edge:
  - dout <= ram_o (the word at rd_ptr); dout_valid <= 1.
  - rd_ptr += 1 modulo depth; count -= 1.
- Read latency: dout_valid rises in the cycle after the pop_ack cycle.
  - dout holds its value until the next pop.
  - dout_valid drops to 0 after one cycle unless there is another pop_ack.
- Flags are recomputed from the next count value, so they are valid in the same cycle count changes.
- Pointers are ADDRESS_WIDTH bits and wrap naturally from depth-1 to 0; count disambiguates full from empty.
- Boundaries:
  - Push while full gives push_ack=0, no state change.
  - Pop while empty gives pop_ack=0, dout unchanged.
  - Push and pop together while empty: push is accepted.
  - Push and pop together while full: pop is accepted.
  - Push and pop together otherwise: pop is accepted and push stalls.
- Write-then-read ordering: a word pushed at edge N is poppable from cycle N+1. The RAM register updates at that edge, so ram_o reflects it in the next cycle.

Decomposition:
- Shared include: localparam DEPTH = 1<<ADDRESS_WIDTH and COUNT_WIDTH = ADDRESS_WIDTH+1, reused by the RAM test benches.
- Sub-module `ptr_counter`: ADDRESS_WIDTH-bit wrapping up-counter with enable and async active-low clear, instantiated for wr_ptr and rd_ptr.
- Occupancy and the flags stay in the top module.

Test Plan (ADDRESS_WIDTH=2, depth 4, BUS_WIDTH=8):
- Reset release → count=0, empty=1, full=0, dout_valid=0, ram_st=0; pop held high gives pop_ack=0 with dout unchanged at 0x00.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full=1 and count=4 after the 4th edge; a 5th push of 0x55 gives push_ack=0 and count stays 4.
- Pop four times from full → dout sequence 0x11, 0x22, 0x33, 0x44, each with dout_valid high one cycle after its pop_ack; empty=1 at the end.
- Wrap-around: push 0xA0..0xA5 interleaved with pops so that wr_ptr and rd_ptr wrap past 3 → FIFO order is preserved and count never exceeds 4.
- Simultaneous push 0x77 + pop with count=2 → pop_ack=1, push_ack=0, count=1 next cycle. Push 0x77 held one more cycle → accepted, count=2.
- Assert rst_n low asynchronously between clock edges with count=3 → outputs reset immediately without waiting for clk; after release, empty=1 and the next push of 0x99 pops back 0x99.
